// File: rtl/sd_controller_axi_reader.sv
// AXI4 read master: fetches one 1 KB block as a 256-beat INCR burst into the SD block buffer.
// Optional running checksum output enabled by SD_CONTROLLER_AXI_READER_CHECKSUM_EN.
module sd_controller_axi_reader #(
    localparam int BUFFER_ADDR_WIDTH = 8,
    localparam int BUFFER_DATA_WIDTH = 32,
    localparam int ADDR_WIDTH        = 32
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    output logic                         axi_arvalid,
    input  logic                         axi_arready,
    output logic [ADDR_WIDTH-1:0]        axi_araddr,
    output logic [2:0]                   axi_arprot,
    output logic [1:0]                   axi_arburst,
    output logic [7:0]                   axi_arlen,
    output logic [2:0]                   axi_arsize,
    input  logic                         axi_rvalid,
    output logic                         axi_rready,
    input  logic [BUFFER_DATA_WIDTH-1:0] axi_rdata,
    input  logic [1:0]                   axi_rresp,
    input  logic                         axi_rlast,
    output logic [BUFFER_ADDR_WIDTH-1:0] buffer_addr,
    output logic [BUFFER_DATA_WIDTH-1:0] buffer_data,
    output logic                         buffer_we,
    input  logic [ADDR_WIDTH-1:0]        initial_addr,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         err
`ifdef SD_CONTROLLER_AXI_READER_CHECKSUM_EN
    ,
    output logic [BUFFER_DATA_WIDTH-1:0] checksum
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-3:0]   addr_word;
    logic [8:0]              beat_cnt;
    logic                    overflow;
    logic                    err_acc;
    logic                    accept_start;
    logic                    beat;
    logic                    burst_end;
    logic                    beat_err;

    assign accept_start = (state == IDLE) && start;
    assign beat         = axi_rvalid && axi_rready;
    assign burst_end    = (state == DATA) && beat && axi_rlast;
    // A bad response or an rlast anywhere but beat 255 marks the transfer as failed.
    assign beat_err     = (axi_rresp != 2'b00) || (axi_rlast && (beat_cnt != 9'd255));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)       state_next = ADDR;
            ADDR:    if (axi_arready) state_next = DATA;
            DATA:    if (burst_end)   state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= IDLE;
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b0;
            addr_word   <= '0;
            beat_cnt    <= '0;
            overflow    <= 1'b0;
            err_acc     <= 1'b0;
            err         <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            axi_arvalid <= (state_next == ADDR);
            axi_rready  <= (state_next != IDLE);
            done        <= burst_end;
            if (accept_start) begin
                addr_word <= initial_addr[ADDR_WIDTH-1:2];
            end
            if ((state == IDLE) || burst_end) begin
                beat_cnt <= '0;
                overflow <= 1'b0;
                err_acc  <= 1'b0;
            end else if (beat) begin
                // Counter saturates at 256 so excess beats can never alias into the buffer.
                if (beat_cnt[8]) begin
                    overflow <= 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + 9'd1;
                end
                err_acc <= err_acc | beat_err;
            end
            if (burst_end) begin
                err <= err_acc | overflow | beat_err;
            end
        end
    end

    assign axi_araddr  = {addr_word, 2'b00};
    assign axi_arprot  = 3'b000;
    assign axi_arburst = 2'b01;
    assign axi_arlen   = 8'hFF;
    assign axi_arsize  = 3'b010;

    assign buffer_we   = beat && !beat_cnt[8];
    assign buffer_data = axi_rdata;
    assign buffer_addr = beat_cnt[BUFFER_ADDR_WIDTH-1:0];
    assign busy        = (state != IDLE);

`ifdef SD_CONTROLLER_AXI_READER_CHECKSUM_EN
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            checksum <= '0;
        end else if (accept_start) begin
            checksum <= '0;
        end else if (buffer_we) begin
            checksum <= checksum + axi_rdata;
        end
    end
`endif

endmodule
